// File: rtl/cache_set_assoc.sv
// cache_set_assoc: write-back, write-allocate set-associative cache with FIFO or LRU
// replacement and a single-line swap port to main memory.
module cache_set_assoc #(
  parameter int LINE_ADDR_LEN  = 3,
  parameter int INDEX_ADDR_LEN = 3,
  parameter int TAG_ADDR_LEN   = 6,
  parameter int WAY_CNT        = 4,
  parameter int REPLACE_POLICY = 1,
  localparam int MEM_ADDR_LEN  = TAG_ADDR_LEN + INDEX_ADDR_LEN,
  localparam int LINE_W        = 32 << LINE_ADDR_LEN
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             addr,
  input  logic                    rd_req,
  input  logic                    wr_req,
  input  logic [31:0]             wr_data,
  output logic [31:0]             rd_data,
  output logic                    miss,
  output logic [MEM_ADDR_LEN-1:0] mem_addr,
  output logic                    mem_rd_req,
  output logic                    mem_wr_req,
  output logic [LINE_W-1:0]       mem_wr_line,
  input  logic [LINE_W-1:0]       mem_rd_line,
  input  logic                    mem_gnt,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt
);
  localparam int SETS   = 1 << INDEX_ADDR_LEN;
  localparam int AW     = (WAY_CNT > 1) ? $clog2(WAY_CNT) : 1;
  localparam int IDX_LO = LINE_ADDR_LEN + 2;
  localparam int TAG_LO = IDX_LO + INDEX_ADDR_LEN;
  localparam int TAG_HI = TAG_LO + TAG_ADDR_LEN - 1;

  typedef enum logic [1:0] {IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK} state_t;

  state_t                    state_q, state_d;
  logic [LINE_W-1:0]         line_q  [SETS][WAY_CNT];
  logic [TAG_ADDR_LEN-1:0]   tags_q  [SETS][WAY_CNT];
  logic [AW-1:0]             age_q   [SETS][WAY_CNT];
  logic [WAY_CNT-1:0]        valid_q [SETS];
  logic [WAY_CNT-1:0]        dirty_q [SETS];
  logic [AW-1:0]             fifo_q  [SETS];
  logic [AW-1:0]             vic_q;
  logic                      vic_valid_q;
  logic [INDEX_ADDR_LEN-1:0] set_q;
  logic [TAG_ADDR_LEN-1:0]   req_tag_q, wb_tag_q;
  logic [LINE_W-1:0]         wb_line_q;
  logic [31:0]               hit_cnt_q, miss_cnt_q;
  logic [LINE_ADDR_LEN-1:0]  word_idx;
  logic [INDEX_ADDR_LEN-1:0] set_idx, touch_set;
  logic [TAG_ADDR_LEN-1:0]   req_tag;
  logic [AW-1:0]             hit_way, lru_way, vic, touch_way;
  logic                      way_hit, hit, req, touch_en, addr_unused;

  assign word_idx    = addr[IDX_LO-1:2];
  assign set_idx     = addr[TAG_LO-1:IDX_LO];
  assign req_tag     = addr[TAG_HI:TAG_LO];
  assign addr_unused = ^{addr[31:TAG_HI+1], addr[1:0]};
  assign req         = rd_req | wr_req;
  assign hit         = (state_q == IDLE) & way_hit;
  assign miss        = req & ~hit;
  assign rd_data     = line_q[set_idx][hit_way][{word_idx, 5'd0} +: 32];
  assign mem_wr_req  = state_q == SWAP_OUT;
  assign mem_rd_req  = state_q == SWAP_IN;
  assign mem_addr    = (state_q == SWAP_OUT) ? {wb_tag_q, set_q} :
                       (state_q == SWAP_IN)  ? {req_tag_q, set_q} : '0;
  assign mem_wr_line = wb_line_q;
  assign hit_cnt     = hit_cnt_q;
  assign miss_cnt    = miss_cnt_q;
  // A fill and a hit never coincide, so one recency update port serves both.
  assign touch_en    = (hit & req) | (state_q == SWAP_IN_OK);
  assign touch_set   = (state_q == IDLE) ? set_idx : set_q;
  assign touch_way   = (state_q == IDLE) ? hit_way : vic_q;

  always_comb begin
    way_hit = 1'b0;
    hit_way = '0;
    lru_way = '0;
    for (int w = 0; w < WAY_CNT; w++) begin
      if (valid_q[set_idx][w] && tags_q[set_idx][w] == req_tag) begin
        way_hit = 1'b1;
        hit_way = AW'(w);
      end
      if (age_q[set_idx][w] == AW'(WAY_CNT - 1)) lru_way = AW'(w);
    end
    vic = (REPLACE_POLICY == 0) ? fifo_q[set_idx] : lru_way;
    for (int w = WAY_CNT - 1; w >= 0; w--)
      if (!valid_q[set_idx][w]) vic = AW'(w);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (miss) state_d = (valid_q[set_idx][vic] && dirty_q[set_idx][vic]) ? SWAP_OUT : SWAP_IN;
      SWAP_OUT:   if (mem_gnt) state_d = SWAP_IN;
      SWAP_IN:    if (mem_gnt) state_d = SWAP_IN_OK;
      SWAP_IN_OK: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && miss) begin
      vic_q       <= vic;
      vic_valid_q <= valid_q[set_idx][vic];
      set_q       <= set_idx;
      req_tag_q   <= req_tag;
      wb_tag_q    <= tags_q[set_idx][vic];
      wb_line_q   <= line_q[set_idx][vic];
    end
    if (hit && wr_req) line_q[set_idx][hit_way][{word_idx, 5'd0} +: 32] <= wr_data;
    if (state_q == SWAP_IN_OK) begin
      line_q[set_q][vic_q] <= mem_rd_line;
      tags_q[set_q][vic_q] <= req_tag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        fifo_q[s]  <= '0;
        for (int w = 0; w < WAY_CNT; w++) age_q[s][w] <= AW'(w);
      end
    end else begin
      state_q <= state_d;
      if (hit && req) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (hit && wr_req) dirty_q[set_idx][hit_way] <= 1'b1;
      if (state_q == IDLE && miss) miss_cnt_q <= miss_cnt_q + 32'd1;
      if (state_q == SWAP_IN_OK) begin
        valid_q[set_q][vic_q] <= 1'b1;
        dirty_q[set_q][vic_q] <= 1'b0;
        if (vic_valid_q) fifo_q[set_q] <= AW'((int'(fifo_q[set_q]) + 1) % WAY_CNT);
      end
      if (touch_en)
        for (int w = 0; w < WAY_CNT; w++)
          age_q[touch_set][w] <= (AW'(w) == touch_way) ? '0 :
                                 (age_q[touch_set][w] < age_q[touch_set][touch_way]) ? age_q[touch_set][w] + AW'(1) :
                                 age_q[touch_set][w];
    end
  end
endmodule

// File: tb/tb_cache_set_assoc.sv
// tb_cache_set_assoc: random and directed traffic against a flat-memory and recency-list model,
// with a queue-based scoreboard checked by independent monitor and memory-responder processes.
module tb_cache_set_assoc;
  localparam int WAYS = 4;
  localparam int SETS = 8;
  localparam int POL  = 1;
  localparam int LW   = 256;
  localparam int MA   = 9;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    bit          miss;
    int          hits;
    int          misses;
  } exp_t;
  typedef struct {
    logic [MA-1:0] la;
    logic [LW-1:0] line;
  } wb_t;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [31:0]   addr = '0, wr_data = '0;
  logic          rd_req = 1'b0, wr_req = 1'b0;
  logic [31:0]   rd_data, hit_cnt, miss_cnt;
  logic          miss, mem_rd_req, mem_wr_req;
  logic [MA-1:0] mem_addr;
  logic [LW-1:0] mem_wr_line;
  logic [LW-1:0] mem_rd_line = '0;
  logic          mem_gnt = 1'b0;

  exp_t          sb[$];
  wb_t           wb_q[$];
  logic [MA-1:0] fill_q[$];
  int            tests = 0, fails = 0;
  logic [31:0]   backing[4096];
  logic [31:0]   shadow[4096];
  bit            m_valid[SETS][WAYS];
  bit            m_dirty[SETS][WAYS];
  int            m_tag[SETS][WAYS];
  int            rec[SETS][$];
  int            ptr[SETS];
  int            served, misses;

  cache_set_assoc dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .rd_req(rd_req), .wr_req(wr_req),
    .wr_data(wr_data), .rd_data(rd_data), .miss(miss), .mem_addr(mem_addr),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_wr_line(mem_wr_line),
    .mem_rd_line(mem_rd_line), .mem_gnt(mem_gnt), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endfunction

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  function automatic logic [LW-1:0] line_of(int la);
    logic [LW-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = shadow[la*8 + i];
    return r;
  endfunction

  // Most recently used way sits at the front; the reset ages make way 0 the most recent.
  function automatic void touch(int s, int w);
    int q[$];
    q.push_back(w);
    for (int i = 0; i < rec[s].size(); i++)
      if (rec[s][i] != w) q.push_back(rec[s][i]);
    rec[s] = q;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++) begin
      rec[s] = {};
      ptr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        rec[s].push_back(w);
      end
    end
    for (int i = 0; i < 4096; i++) shadow[i] = backing[i];
    served = 0;
    misses = 0;
  endfunction

  function automatic void model_issue(bit rd, bit wr, logic [31:0] a, logic [31:0] d);
    int s, t, wi, hw, v;
    exp_t e;
    wb_t b;
    s  = int'(a[7:5]);
    t  = int'(a[13:8]);
    wi = int'(a[13:2]);
    hw = -1;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
    e.rd   = rd;
    e.data = shadow[wi];
    e.miss = (hw < 0);
    if (hw < 0) begin
      v = -1;
      for (int w = WAYS - 1; w >= 0; w--)
        if (!m_valid[s][w]) v = w;
      if (v < 0) v = (POL != 0) ? rec[s][$] : ptr[s];
      if (m_valid[s][v]) begin
        if (m_dirty[s][v]) begin
          b.la   = MA'(m_tag[s][v] * SETS + s);
          b.line = line_of(m_tag[s][v] * SETS + s);
          wb_q.push_back(b);
        end
        ptr[s] = (ptr[s] + 1) % WAYS;
      end
      fill_q.push_back(a[13:5]);
      m_valid[s][v] = 1'b1;
      m_tag[s][v]   = t;
      m_dirty[s][v] = 1'b0;
      touch(s, v);
      hw = v;
      misses++;
    end
    touch(s, hw);
    if (wr) begin
      m_dirty[s][hw] = 1'b1;
      shadow[wi] = d;
    end
    e.hits   = served;
    e.misses = misses;
    served++;
    sb.push_back(e);
  endfunction

  task automatic req(bit rd, bit wr, logic [31:0] a, logic [31:0] d);
    int n;
    n = 0;
    model_issue(rd, wr, a, d);
    rd_req  = rd;
    wr_req  = wr;
    addr    = a;
    wr_data = d;
    do begin
      @(negedge clk);
      n++;
    end while (miss && n < 64);
    if (miss) begin
      tests++;
      fails++;
      $display("FAIL req_timeout: addr %0h still missing after %0d cycles, required served", a, n);
      finish_run();
    end
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    wr_req = 1'b0;
  endtask

  initial begin : monitor
    bit saw;
    exp_t e;
    saw = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) saw = 1'b0;
      else begin
        chk("mem_req_exclusive", LW'(mem_rd_req & mem_wr_req), '0);
        chk("mem_addr_idle", LW'((mem_rd_req | mem_wr_req) ? '0 : mem_addr), '0);
        if (rd_req | wr_req) begin
          if (miss) saw = 1'b1;
          else if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_unexpected: served request with empty scoreboard, required none");
          end else begin
            e = sb.pop_front();
            if (e.rd) chk("rd_data", LW'(rd_data), LW'(e.data));
            chk("first_cycle_miss", LW'(saw), LW'(e.miss));
            chk("hit_cnt", LW'(hit_cnt), LW'(e.hits));
            chk("miss_cnt", LW'(miss_cnt), LW'(e.misses));
            saw = 1'b0;
          end
        end
      end
    end
  end

  initial begin : responder
    int cnt, dly;
    wb_t w;
    cnt = 0;
    dly = 0;
    forever begin
      @(posedge clk);
      #1;
      mem_gnt = 1'b0;
      if (!rst_n || !(mem_rd_req || mem_wr_req)) cnt = 0;
      else if (cnt < dly) cnt++;
      else begin
        mem_gnt = 1'b1;
        cnt = 0;
        dly = $urandom_range(0, 3);
        if (mem_wr_req) begin
          for (int i = 0; i < 8; i++) backing[int'(mem_addr)*8 + i] = mem_wr_line[i*32 +: 32];
          if (wb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL wb_unexpected: write-back of line %0h, required none", mem_addr);
          end else begin
            w = wb_q.pop_front();
            chk("wb_addr", LW'(mem_addr), LW'(w.la));
            chk("wb_line", mem_wr_line, w.line);
          end
        end else begin
          for (int i = 0; i < 8; i++) mem_rd_line[i*32 +: 32] = backing[int'(mem_addr)*8 + i];
          if (fill_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL fill_unexpected: fill of line %0h, required none", mem_addr);
          end else chk("fill_addr", LW'(mem_addr), LW'(fill_q.pop_front()));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    tests++;
    fails++;
    $display("FAIL watchdog: run exceeded time limit");
    finish_run();
  end

  initial begin : stim
    int n;
    for (int i = 0; i < 4096; i++) backing[i] = $urandom;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hit_cnt", LW'(hit_cnt), '0);
    chk("rst_miss_cnt", LW'(miss_cnt), '0);
    chk("rst_mem_rd_req", LW'(mem_rd_req), '0);
    chk("rst_mem_wr_req", LW'(mem_wr_req), '0);
    chk("rst_idle_miss", LW'(miss), '0);
    chk("rst_mem_addr", LW'(mem_addr), '0);
    rst_n = 1'b1;
    req(1'b1, 1'b0, 32'h000, '0);
    chk("first_read_miss_cnt", LW'(miss_cnt), LW'(1));
    req(1'b1, 1'b0, 32'h104, '0);
    req(1'b0, 1'b1, 32'h104, 32'hDEADBEEF);
    req(1'b1, 1'b0, 32'h104, '0);
    chk("hit_cnt_after_write", LW'(hit_cnt), LW'(4));
    req(1'b1, 1'b0, 32'h200, '0);
    req(1'b1, 1'b0, 32'h300, '0);
    req(1'b1, 1'b0, 32'h000, '0);
    req(1'b1, 1'b0, 32'h400, '0);
    req(1'b1, 1'b0, 32'h104, '0);
    req(1'b0, 1'b1, 32'h008, 32'h12345678);
    req(1'b1, 1'b0, 32'h500, '0);
    req(1'b1, 1'b0, 32'h600, '0);
    req(1'b1, 1'b0, 32'h700, '0);
    req(1'b1, 1'b0, 32'h800, '0);
    req(1'b1, 1'b1, 32'h008, 32'h0BADF00D);
    for (int k = 0; k < 400; k++) begin
      logic [31:0] a;
      int op;
      a  = {18'd0, 6'($urandom_range(0, 7)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'b00};
      op = $urandom_range(0, 2);
      req(op != 1, op != 0, a, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    fill_q.push_back(9'h0E5);
    rd_req = 1'b1;
    addr   = 32'h1CA0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_rd_req && n < 64);
    chk("swap_in_reached", LW'(mem_rd_req), LW'(1));
    rst_n  = 1'b0;
    rd_req = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_mem_rd_req", LW'(mem_rd_req), '0);
    chk("abort_mem_wr_req", LW'(mem_wr_req), '0);
    chk("abort_miss_cnt", LW'(miss_cnt), '0);
    fill_q.delete();
    wb_q.delete();
    sb.delete();
    model_reset();
    rst_n = 1'b1;
    req(1'b1, 1'b0, 32'h1CA0, '0);
    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", LW'(sb.size()), '0);
    chk("wb_drained", LW'(wb_q.size()), '0);
    chk("fill_drained", LW'(fill_q.size()), '0);
    finish_run();
  end
endmodule
